// File: rtl/half_adder_rr_arbiter_pkg.sv
// Shared types for the round-robin half-adder arbiter: result-register FSM
// states and requester ID encodings.
package half_adder_arb_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } resState_t;

   localparam logic ID0 = 1'b0;
   localparam logic ID1 = 1'b1;

endpackage

// File: rtl/half_adder_rr_arbiter_adder.sv
// Combinational WIDTH-bit adder with no carry-in; the MSB carry is exposed
// separately so the sum wraps on overflow.
module param_half_adder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/half_adder_rr_arbiter.sv
// Two requesters share one param_half_adder through a round-robin arbiter;
// results are registered onto a single valid/ready channel tagged with the ID.
module half_adder_rr_arbiter
   import half_adder_arb_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_cout,
   output logic             res_id,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1
);

   resState_t        r_state;
   resState_t        w_stateNext;
   logic             r_lastGrant;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_id;
   logic [CNT_W-1:0] r_grantCnt0;
   logic [CNT_W-1:0] r_grantCnt1;

   logic             w_canAccept;
   logic             w_grant0;
   logic             w_grant1;
   logic             w_grant;
   logic [WIDTH-1:0] w_opA;
   logic [WIDTH-1:0] w_opB;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;

   // Requester 0 wins a tie when requester 1 held the last grant, and vice versa.
   always_comb begin
      w_canAccept = (r_state == ST_EMPTY) || res_ready;
      w_grant0    = 1'b0;
      w_grant1    = 1'b0;
      if (!rst && w_canAccept) begin
         if (req0_valid && (!req1_valid || (r_lastGrant == ID1))) begin
            w_grant0 = 1'b1;
         end else if (req1_valid) begin
            w_grant1 = 1'b1;
         end
      end
   end

   assign w_grant    = w_grant0 | w_grant1;
   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;

   assign w_opA = w_grant1 ? req1_a : req0_a;
   assign w_opB = w_grant1 ? req1_b : req0_b;

   param_half_adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a    (w_opA),
      .b    (w_opB),
      .s    (w_sum),
      .cout (w_cout)
   );

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_EMPTY: if (w_grant) w_stateNext = ST_FULL;
         ST_FULL:  if (res_ready && !w_grant) w_stateNext = ST_EMPTY;
         default:  w_stateNext = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_EMPTY;
         r_lastGrant <= ID1;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_id        <= ID0;
         r_grantCnt0 <= '0;
         r_grantCnt1 <= '0;
      end else begin
         r_state <= w_stateNext;
         if (w_grant) begin
            r_sum       <= w_sum;
            r_cout      <= w_cout;
            r_id        <= w_grant1 ? ID1 : ID0;
            r_lastGrant <= w_grant1 ? ID1 : ID0;
         end
         // Counters stick at all-ones rather than wrapping.
         if (w_grant0 && (r_grantCnt0 != {CNT_W{1'b1}})) begin
            r_grantCnt0 <= r_grantCnt0 + 1'b1;
         end
         if (w_grant1 && (r_grantCnt1 != {CNT_W{1'b1}})) begin
            r_grantCnt1 <= r_grantCnt1 + 1'b1;
         end
      end
   end

   assign res_valid  = (r_state == ST_FULL);
   assign res_sum    = r_sum;
   assign res_cout   = r_cout;
   assign res_id     = r_id;
   assign grant_cnt0 = r_grantCnt0;
   assign grant_cnt1 = r_grantCnt1;

endmodule

// File: tb/tb_half_adder_rr_arbiter.sv
// Directed bench for half_adder_rr_arbiter with WIDTH=4, CNT_W=4.
module tb_half_adder_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0Valid, req1Valid, resReady;
   logic [3:0] req0A, req0B, req1A, req1B;
   logic       req0Ready, req1Ready, resValid, resCout, resId;
   logic [3:0] resSum, grantCnt0, grantCnt1;

   int nCompared   = 0;
   int nMismatched = 0;

   always #5 clk = ~clk;

   half_adder_rr_arbiter #(
      .WIDTH (4),
      .CNT_W (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0Valid),
      .req0_a     (req0A),
      .req0_b     (req0B),
      .req0_ready (req0Ready),
      .req1_valid (req1Valid),
      .req1_a     (req1A),
      .req1_b     (req1B),
      .req1_ready (req1Ready),
      .res_valid  (resValid),
      .res_ready  (resReady),
      .res_sum    (resSum),
      .res_cout   (resCout),
      .res_id     (resId),
      .grant_cnt0 (grantCnt0),
      .grant_cnt1 (grantCnt1)
   );

   // Advance one edge and sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      req0Valid = 1'b0; req1Valid = 1'b0;
      req0A = 4'h0; req0B = 4'h0; req1A = 4'h0; req1B = 4'h0;
   endtask

   task automatic doReset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] got;
      $display("[TB] test_reset");
      idleInputs();
      resReady = 1'b1;
      req0Valid = 1'b1; req1Valid = 1'b1;
      rst = 1'b1;
      step();
      step();
      #1;
      nCompared++;
      if ({req0Ready, req1Ready} !== 2'b00) begin
         nMismatched++;
         $display("FAIL reset_ready got %b want 00", {req0Ready, req1Ready});
      end
      got = {resValid, resCout, resSum, resId};
      nCompared++;
      if (got !== 7'b0) begin
         nMismatched++;
         $display("FAIL reset_res got %b want 0000000", got);
      end
      nCompared++;
      if ({grantCnt0, grantCnt1} !== 8'h00) begin
         nMismatched++;
         $display("FAIL reset_cnt got %h want 00", {grantCnt0, grantCnt1});
      end
      idleInputs();
      rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      $display("[TB] test_single");
      resReady = 1'b1;
      req0Valid = 1'b1; req0A = 4'b0011; req0B = 4'b0100;
      #1;
      nCompared++;
      if ({req0Ready, req1Ready} !== 2'b10) begin
         nMismatched++;
         $display("FAIL single_ready got %b want 10", {req0Ready, req1Ready});
      end
      step();
      idleInputs();
      nCompared++;
      if ({resValid, resCout, resSum, resId} !== {1'b1, 1'b0, 4'b0111, 1'b0}) begin
         nMismatched++;
         $display("FAIL single_res got %b want 1001110", {resValid, resCout, resSum, resId});
      end
      nCompared++;
      if (grantCnt0 !== 4'd1) begin
         nMismatched++;
         $display("FAIL single_cnt0 got %0d want 1", grantCnt0);
      end
      step();
      nCompared++;
      if (resValid !== 1'b0) begin
         nMismatched++;
         $display("FAIL single_drain got %b want 0", resValid);
      end
   endtask

   task automatic test_contention();
      $display("[TB] test_contention");
      doReset();
      resReady = 1'b1;
      req0Valid = 1'b1; req0A = 4'b1111; req0B = 4'b0001;
      req1Valid = 1'b1; req1A = 4'b0110; req1B = 4'b1111;
      #1;
      nCompared++;
      if ({req0Ready, req1Ready} !== 2'b10) begin
         nMismatched++;
         $display("FAIL cont_first_ready got %b want 10", {req0Ready, req1Ready});
      end
      step();
      nCompared++;
      if ({resValid, resCout, resSum, resId} !== {1'b1, 1'b1, 4'b0000, 1'b0}) begin
         nMismatched++;
         $display("FAIL cont_first_res got %b want 1100000", {resValid, resCout, resSum, resId});
      end
      nCompared++;
      if ({req0Ready, req1Ready} !== 2'b01) begin
         nMismatched++;
         $display("FAIL cont_second_ready got %b want 01", {req0Ready, req1Ready});
      end
      step();
      nCompared++;
      if ({resValid, resCout, resSum, resId} !== {1'b1, 1'b1, 4'b0101, 1'b1}) begin
         nMismatched++;
         $display("FAIL cont_second_res got %b want 1101011", {resValid, resCout, resSum, resId});
      end
      nCompared++;
      if ({req0Ready, req1Ready} !== 2'b10) begin
         nMismatched++;
         $display("FAIL cont_third_ready got %b want 10", {req0Ready, req1Ready});
      end
      idleInputs();
      step();
   endtask

   task automatic test_backpressure();
      $display("[TB] test_backpressure");
      resReady = 1'b1;
      req0Valid = 1'b1; req0A = 4'd2; req0B = 4'd5;
      step();
      resReady = 1'b0;
      req0A = 4'd1; req0B = 4'd1;
      req1Valid = 1'b1; req1A = 4'd9; req1B = 4'd9;
      for (int k = 0; k < 5; k++) begin
         #1;
         nCompared++;
         if ({req0Ready, req1Ready} !== 2'b00) begin
            nMismatched++;
            $display("FAIL bp_ready[%0d] got %b want 00", k, {req0Ready, req1Ready});
         end
         nCompared++;
         if ({resValid, resCout, resSum, resId} !== {1'b1, 1'b0, 4'b0111, 1'b0}) begin
            nMismatched++;
            $display("FAIL bp_hold[%0d] got %b want 1001110", k, {resValid, resCout, resSum, resId});
         end
         step();
      end
      resReady = 1'b1;
      #1;
      nCompared++;
      if ({req0Ready, req1Ready} !== 2'b01) begin
         nMismatched++;
         $display("FAIL bp_release_ready got %b want 01", {req0Ready, req1Ready});
      end
      step();
      idleInputs();
      nCompared++;
      if ({resValid, resCout, resSum, resId} !== {1'b1, 1'b1, 4'b0010, 1'b1}) begin
         nMismatched++;
         $display("FAIL bp_release_res got %b want 1100101", {resValid, resCout, resSum, resId});
      end
      step();
   endtask

   task automatic test_stream();
      logic [4:0] expect5;
      logic [3:0] expCnt;
      $display("[TB] test_stream");
      doReset();
      resReady = 1'b1;
      req1Valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         req1A = 4'(i);
         req1B = 4'd3;
         expect5 = 5'(i % 16) + 5'd3;
         expCnt = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
         #1;
         nCompared++;
         if (req1Ready !== 1'b1) begin
            nMismatched++;
            $display("FAIL stream_ready[%0d] got %b want 1", i, req1Ready);
         end
         step();
         nCompared++;
         if ({resValid, resCout, resSum, resId} !== {1'b1, expect5, 1'b1}) begin
            nMismatched++;
            $display("FAIL stream_res[%0d] got %b want %b", i, {resValid, resCout, resSum, resId}, {1'b1, expect5, 1'b1});
         end
         nCompared++;
         if (grantCnt1 !== expCnt) begin
            nMismatched++;
            $display("FAIL stream_cnt1[%0d] got %0d want %0d", i, grantCnt1, expCnt);
         end
      end
   endtask

   task automatic test_reset_mid();
      $display("[TB] test_reset_mid");
      nCompared++;
      if (resValid !== 1'b1) begin
         nMismatched++;
         $display("FAIL mid_pre_valid got %b want 1", resValid);
      end
      req0Valid = 1'b1; req0A = 4'd4; req0B = 4'd4;
      rst = 1'b1;
      #1;
      nCompared++;
      if ({req0Ready, req1Ready} !== 2'b00) begin
         nMismatched++;
         $display("FAIL mid_rst_ready got %b want 00", {req0Ready, req1Ready});
      end
      step();
      rst = 1'b0;
      #1;
      nCompared++;
      if ({resValid, grantCnt0, grantCnt1} !== 9'b0) begin
         nMismatched++;
         $display("FAIL mid_cleared got %b want 000000000", {resValid, grantCnt0, grantCnt1});
      end
      nCompared++;
      if ({req0Ready, req1Ready} !== 2'b10) begin
         nMismatched++;
         $display("FAIL mid_winner got %b want 10", {req0Ready, req1Ready});
      end
      step();
      idleInputs();
      nCompared++;
      if ({resValid, resCout, resSum, resId} !== {1'b1, 1'b0, 4'b1000, 1'b0}) begin
         nMismatched++;
         $display("FAIL mid_res got %b want 1010000", {resValid, resCout, resSum, resId});
      end
      step();
   endtask

   task automatic test_exhaustive();
      logic [7:0] idx;
      logic [4:0] expect5;
      logic       src;
      $display("[TB] test_exhaustive");
      resReady = 1'b1;
      for (int i = 0; i < 256; i++) begin
         idx = 8'(i);
         src = idx[0];
         expect5 = {1'b0, idx[7:4]} + {1'b0, idx[3:0]};
         idleInputs();
         if (src) begin
            req1Valid = 1'b1; req1A = idx[7:4]; req1B = idx[3:0];
         end else begin
            req0Valid = 1'b1; req0A = idx[7:4]; req0B = idx[3:0];
         end
         #1;
         nCompared++;
         if ({req0Ready, req1Ready} !== {~src, src}) begin
            nMismatched++;
            $display("FAIL exh_ready[%0d] got %b want %b", i, {req0Ready, req1Ready}, {~src, src});
         end
         step();
         nCompared++;
         if ({resValid, resCout, resSum, resId} !== {1'b1, expect5, src}) begin
            nMismatched++;
            $display("FAIL exh_res[%0d] got %b want %b", i, {resValid, resCout, resSum, resId}, {1'b1, expect5, src});
         end
      end
      idleInputs();
      step();
   endtask

   initial begin
      rst = 1'b1;
      resReady = 1'b0;
      idleInputs();
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_stream();
      test_reset_mid();
      test_exhaustive();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
